// File: rtl/rtob_dispatch_ctrl.sv
// RTOB dispatch controller: steers timestamped host commands to per-core write
// ports, owns the shared auto_start run control, flush sequencing and sticky errors.
module rtob_dispatch_ctrl #(
  parameter int NUM_CH       = 8,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [127:0]        s_data,
  input  logic [CH_W-1:0]     s_ch,
  input  logic [NUM_CH-1:0]   flush_req,
  input  logic                start_req,
  input  logic [63:0]         start_time,
  input  logic                stop_req,
  input  logic [63:0]         counter,
  input  logic [NUM_CH-1:0]   core_full,
  input  logic [NUM_CH-1:0]   core_ts_err,
  input  logic [NUM_CH-1:0]   core_ovf_err,
  output logic [NUM_CH-1:0]   core_write,
  output logic [127:0]        core_din,
  output logic [NUM_CH-1:0]   core_flush,
  output logic                core_auto_start,
  input  logic                err_clear,
  output logic [NUM_CH-1:0]   ts_err_sticky,
  output logic [NUM_CH-1:0]   ovf_err_sticky,
  output logic                bad_ch_sticky,
  output logic [1:0]          state,
  output logic [31:0]         wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_e              state_q, state_d;
  logic [63:0]         start_q, start_d;
  logic [NUM_CH-1:0]   flush_q, flush_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic                auto_q, auto_d;
  logic [NUM_CH-1:0]   wr_q, wr_d;
  logic [127:0]        din_q, din_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ts_q, ts_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic                bad_q, bad_d;

  logic [NUM_CH-1:0]   ch_oh;
  logic                ch_ok, ch_full, hs, good_wr, flush_any;

  // Decode by comparison so out-of-range selects simply decode to zero.
  always_comb begin
    ch_oh = '0;
    for (int i = 0; i < NUM_CH; i++) ch_oh[i] = (s_ch == CH_W'(i));
  end

  assign ch_ok     = |ch_oh;
  assign ch_full   = |(ch_oh & core_full);
  assign s_ready   = (state_q != FLUSH) && !ch_full;
  assign hs        = s_valid && s_ready;
  assign good_wr   = hs && ch_ok;
  assign flush_any = |flush_req;

  always_comb begin
    wr_d  = good_wr ? ch_oh : '0;
    din_d = good_wr ? s_data : din_q;
    cnt_d = cnt_q + 32'(good_wr);
    // Set beats clear when both land in the same cycle.
    ts_d  = (err_clear ? '0 : ts_q)  | core_ts_err;
    ovf_d = (err_clear ? '0 : ovf_q) | core_ovf_err;
    bad_d = (err_clear ? 1'b0 : bad_q) | (hs && !ch_ok);
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    flush_d = flush_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (flush_any) begin
          state_d = FLUSH;
          flush_d = flush_req;
          fcnt_d  = CNT_W'(FLUSH_CYCLES);
        end else if (start_req) begin
          state_d = ARMED;
          start_d = start_time;
        end
      end
      ARMED: begin
        if (flush_any) begin
          state_d = FLUSH;
          flush_d = flush_req;
          fcnt_d  = CNT_W'(FLUSH_CYCLES);
        end else if (stop_req) begin
          state_d = IDLE;
        end else if (start_req) begin
          start_d = start_time;
        end else if (counter >= start_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_any) begin
          state_d = FLUSH;
          flush_d = flush_req;
          fcnt_d  = CNT_W'(FLUSH_CYCLES);
        end else if (stop_req) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - CNT_W'(1);
        if (fcnt_q <= CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    auto_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= '0;
      flush_q <= '0;
      fcnt_q  <= '0;
      auto_q  <= 1'b0;
      wr_q    <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
      ovf_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      auto_q  <= auto_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign core_flush      = (state_q == FLUSH && fcnt_q != '0) ? flush_q : '0;
  assign core_write      = wr_q;
  assign core_din        = din_q;
  assign core_auto_start = auto_q;
  assign ts_err_sticky   = ts_q;
  assign ovf_err_sticky  = ovf_q;
  assign bad_ch_sticky   = bad_q;
  assign state           = state_q;
  assign wr_count        = cnt_q;

endmodule
